seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode-select 7-segment display. Holds a double-buffered display value, sequences one digit per refresh slot, encodes each nibble to segments with an internal hex-to-segment encoder, and drives the shared segment bus plus per-digit enables. It sits between the user datapath (which loads values) and the board display pins.

## Interface

- N_DIGITS, 4, number of digits scanned (2..8)
- SLOT_CYC, 50000, clock cycles per digit slot (≥ BLANK_CYC+2)
- BLANK_CYC, 500, cycles at start of each slot with all digits disabled (anti-ghosting, ≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe; capture value/dp_in/lz_en into pending buffer
- value  in  4*N_DIGITS  nibble i drives digit i (digit 0 = rightmost, LSB)
- dp_in  in  N_DIGITS  decimal point per digit
- lz_en  in  1  leading-zero suppression enable
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp  out  1  decimal point, active-high
- com  out  N_DIGITS  digit enables, active-low (1 = off)
- frame_tick  out  1  one-cycle pulse at start of digit-0 slot
- pend  out  1  pending buffer holds a value not yet displayed

## Operation

- Encoder: 0→3F,1→06,2→5B,3→4F,4→66,5→6D,6→7D,7→07,8→7F,9→67,A→77,B→7C,C→39,D→5E,E→79,F→71.
- slot_cnt counts 0..SLOT_CYC-1, wraps; at wrap, digit_idx increments, N_DIGITS-1 wraps to 0.
- State per slot: BLANK (slot_cnt < BLANK_CYC): com all 1, seg=0, dp=0. DRIVE (otherwise): com bit digit_idx = 0, others 1; seg = encoded digit; dp = dp_in latched bit.
- Double buffering: load=1 copies value, dp_in, lz_en into pending regs and sets pend. At frame boundary (slot_cnt wrap into digit_idx 0), display regs ← pending, pend cleared. Display regs never change mid-frame.
- load coincident with frame boundary: load data goes directly to display regs; pend stays 0.
- load while pend=1: pending overwritten (last load wins).
- Leading-zero suppression (display lz_en=1): digit i is blanked (seg=0, com still asserted in DRIVE) if nibbles i..N_DIGITS-1 are all zero and i ≠ 0. dp is not suppressed. Digit 0 always shown.
- Reset mid-operation: all state returns to reset values immediately; pending data discarded.

## Timing

- Reset values: seg=0, dp=0, com=all 1, frame_tick=0, pend=0, slot_cnt=0, digit_idx=0, display regs=0, display lz_en=0.
- All outputs registered; outputs reflect counter state of the previous cycle (1-cycle latency).
- After rst release, first cycle: slot_cnt=0, digit_idx=0 (BLANK). Outputs enter DRIVE for digit 0 at output cycle BLANK_CYC+1.
- frame_tick: asserted in the output cycle corresponding to slot_cnt=0, digit_idx=0, including the first slot after reset.
- pend rises the cycle after load; falls the cycle after the frame boundary.
- New value visible on seg starting with the first DRIVE cycle of the digit-0 slot following the boundary.
- Frame period = N_DIGITS·SLOT_CYC cycles.

## Test plan

Use N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2.
- Reset then idle -> com=1111, seg=00 for 3 output cycles, then com=1110, seg=3F for 6 cycles; frame_tick every 32 cycles.
- load value=16'h1234, dp_in=4'b0100 mid-frame -> pend=1 until next frame boundary; next frame shows digit0 seg=66, digit1 4F, digit2 5B with dp=1, digit3 06; com walks 1110,1101,1011,0111.
- load value=16'h00A0, lz_en=1 -> digits 3,2 seg=00 (com asserted), digit1 seg=77, digit0 seg=3F; value=0 with lz_en=1 -> only digit0 shows 3F.
- Two loads (16'hAAAA then 16'hBEEF) in same frame -> next frame shows BEEF (7C,79,79,71 on digits 3..0); AAAA never displayed.
- load asserted exactly at frame boundary cycle -> value shown in that frame, pend stays 0.
- Assert rst during DRIVE of digit 2 -> next cycle com=1111, seg=00, pend=0; restart from digit 0 with display value 0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of display-side signals for seg_scan_ctrl: user load port in, board pins out.
// The master modport is the user/board side, the slave modport is the controller.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [N_DIGITS-1:0]     com;
  logic                    frame_tick;
  logic                    pend;

  modport master (
    output load, value, dp_in, lz_en,
    input  seg, dp, com, frame_tick, pend
  );

  modport slave (
    input  load, value, dp_in, lz_en,
    output seg, dp, com, frame_tick, pend
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered display value,
// per-slot blanking, leading-zero suppression and registered pin outputs.
module seg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int SW = $clog2(SLOT_CYC);
  localparam int DW = $clog2(N_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);

  logic [SW-1:0]         r_slot_cnt;
  logic [DW-1:0]         r_digit_idx;
  logic [4*N_DIGITS-1:0] r_pend_val;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend_lz;
  logic                  r_pend;
  logic [4*N_DIGITS-1:0] r_disp_val;
  logic [N_DIGITS-1:0]   r_disp_dp;
  logic                  r_disp_lz;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_com;
  logic                  r_tick;

  logic                  w_slot_wrap;
  logic                  w_frame_bnd;
  logic                  w_blank;
  logic                  w_zero_run;
  logic [N_DIGITS-1:0]   w_sup;
  logic [N_DIGITS-1:0]   w_sel;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_sup_bit;
  logic [6:0]            w_seg;
  logic                  w_dp;
  logic [N_DIGITS-1:0]   w_com;
  logic                  w_tick;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = 7'h3F;
      4'h1: seg_encode = 7'h06;
      4'h2: seg_encode = 7'h5B;
      4'h3: seg_encode = 7'h4F;
      4'h4: seg_encode = 7'h66;
      4'h5: seg_encode = 7'h6D;
      4'h6: seg_encode = 7'h7D;
      4'h7: seg_encode = 7'h07;
      4'h8: seg_encode = 7'h7F;
      4'h9: seg_encode = 7'h67;
      4'hA: seg_encode = 7'h77;
      4'hB: seg_encode = 7'h7C;
      4'hC: seg_encode = 7'h39;
      4'hD: seg_encode = 7'h5E;
      4'hE: seg_encode = 7'h79;
      default: seg_encode = 7'h71;
    endcase
  endfunction

  assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
  assign w_frame_bnd = w_slot_wrap && (r_digit_idx == DIG_LAST);
  assign w_blank     = (r_slot_cnt < BLANK_END);
  assign w_tick      = (r_slot_cnt == '0) && (r_digit_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= w_frame_bnd ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the pending stage entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_lz  <= 1'b0;
      r_pend     <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_lz  <= 1'b0;
    end else if (w_frame_bnd && bus.load) begin
      r_disp_val <= bus.value;
      r_disp_dp  <= bus.dp_in;
      r_disp_lz  <= bus.lz_en;
      r_pend     <= 1'b0;
    end else if (w_frame_bnd) begin
      if (r_pend) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_disp_lz  <= r_pend_lz;
      end
      r_pend <= 1'b0;
    end else if (bus.load) begin
      r_pend_val <= bus.value;
      r_pend_dp  <= bus.dp_in;
      r_pend_lz  <= bus.lz_en;
      r_pend     <= 1'b1;
    end
  end

  // A digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_sup      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_disp_val[4*i +: 4] == 4'h0);
      w_sup[i]   = r_disp_lz && w_zero_run && (i != 0);
    end
  end

  always_comb begin
    w_sel     = '0;
    w_nib     = 4'h0;
    w_dp_bit  = 1'b0;
    w_sup_bit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_digit_idx == DW'(i)) begin
        w_sel[i]  = 1'b1;
        w_nib     = r_disp_val[4*i +: 4];
        w_dp_bit  = r_disp_dp[i];
        w_sup_bit = w_sup[i];
      end
    end
  end

  always_comb begin
    w_com = '1;
    w_seg = 7'h00;
    w_dp  = 1'b0;
    if (!w_blank) begin
      w_com = ~w_sel;
      w_seg = w_sup_bit ? 7'h00 : seg_encode(w_nib);
      w_dp  = w_dp_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg  <= 7'h00;
      r_dp   <= 1'b0;
      r_com  <= '1;
      r_tick <= 1'b0;
    end else begin
      r_seg  <= w_seg;
      r_dp   <= w_dp;
      r_com  <= w_com;
      r_tick <= w_tick;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.com        = r_com;
  assign bus.frame_tick = r_tick;
  assign bus.pend       = r_pend;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2): stimulus
// queues the expected first-DRIVE snapshot of every slot, a monitor pops and compares.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS (4),
    .SLOT_CYC (8),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] com;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.frame_tick) got = 1'b1;
    end
    if (!got) begin
      vecs++;
      errs++;
      $display("FAIL frame_tick_timeout: no frame_tick within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    bus.value = v;
    bus.dp_in = d;
    bus.lz_en = lz;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] d);
    q.push_back('{com: 4'b1110, seg: s0, dp: d[0]});
    q.push_back('{com: 4'b1101, seg: s1, dp: d[1]});
    q.push_back('{com: 4'b1011, seg: s2, dp: d[2]});
    q.push_back('{com: 4'b0111, seg: s3, dp: d[3]});
  endtask

  // Monitor: one scoreboard pop at the first DRIVE cycle of every slot.
  initial begin
    logic [3:0] prev;
    int         last;
    exp_t       e;
    prev = 4'hF;
    last = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev = 4'hF;
        last = -1;
      end else begin
        if (bus.frame_tick) begin
          if (last >= 0) chk("frame_period", cyc - last, 32);
          last = cyc;
        end
        if (prev == 4'hF && bus.com != 4'hF) begin
          if (q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL scoreboard_underflow: com=%b seg=%h arrived, expected nothing",
                     bus.com, bus.seg);
          end else begin
            e = q.pop_front();
            chk("slot_com", int'(bus.com), int'(e.com));
            chk("slot_seg", int'(bus.seg), int'(e.seg));
            chk("slot_dp",  int'(bus.dp),  int'(e.dp));
          end
        end
        prev = bus.com;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    bus.dp_in = 4'b0000;
    bus.lz_en = 1'b0;
    step(3);
    chk("reset_com",  int'(bus.com),        4'hF);
    chk("reset_seg",  int'(bus.seg),        0);
    chk("reset_dp",   int'(bus.dp),         0);
    chk("reset_tick", int'(bus.frame_tick), 0);
    chk("reset_pend", int'(bus.pend),       0);
    #1 rst = 1'b0;

    // Idle frame after reset: blank for output cycles 0..2, digit 0 from cycle 3.
    wait_tick();
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      chk("idle_com", int'(bus.com), (c < 3) ? 4'hF : 4'hE);
      chk("idle_seg", int'(bus.seg), (c < 3) ? 0 : 7'h3F);
      if (c < 8) step(1);
    end
    step(2);
    pulse_load(16'h1234, 4'b0100, 1'b0);
    chk("pend_after_load", int'(bus.pend), 1);
    step(20);
    chk("pend_hold_to_boundary", int'(bus.pend), 1);

    wait_tick();
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0100);
    chk("pend_cleared", int'(bus.pend), 0);
    step(5);
    pulse_load(16'h00A0, 4'b0000, 1'b1);

    wait_tick();
    push_frame(7'h3F, 7'h77, 7'h00, 7'h00, 4'b0000);
    step(5);
    pulse_load(16'h0000, 4'b0000, 1'b1);

    wait_tick();
    push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
    step(4);
    pulse_load(16'hAAAA, 4'b0000, 1'b0);
    chk("pend_first_of_two", int'(bus.pend), 1);
    step(7);
    pulse_load(16'hBEEF, 4'b0000, 1'b0);
    chk("pend_second_of_two", int'(bus.pend), 1);

    wait_tick();
    push_frame(7'h71, 7'h79, 7'h79, 7'h7C, 4'b0000);
    step(30);
    pulse_load(16'h5678, 4'b0001, 1'b0);
    chk("pend_boundary_load", int'(bus.pend), 0);

    wait_tick();
    push_frame(7'h7F, 7'h07, 7'h7D, 7'h6D, 4'b0001);
    step(10);
    pulse_load(16'h9999, 4'b0000, 1'b0);
    chk("pend_before_reset", int'(bus.pend), 1);
    step(9);
    #1 rst = 1'b1;
    step(1);
    chk("midrst_com",  int'(bus.com),  4'hF);
    chk("midrst_seg",  int'(bus.seg),  0);
    chk("midrst_dp",   int'(bus.dp),   0);
    chk("midrst_pend", int'(bus.pend), 0);
    q.delete();
    #1 rst = 1'b0;

    wait_tick();
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    chk("pend_after_reset", int'(bus.pend), 0);

    wait_tick();
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    step(28);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
